// File: rtl/pixel_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout_pkg
// Purpose  : Shared types and helpers for the pixel column readout engine.
//            Holds the per-segment FSM state encoding, a constant-foldable
//            ceil(log2) helper and the readout word packing function.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pixel_readout_pkg;

   // Per-segment readout sequence. Explicit 3-bit encoding so the state
   // register width is fixed regardless of tool enum defaults.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // waiting for enable, a hit and FIFO room
      ST_SEL  = 3'd1,   // winner's ADDREN raised
      ST_CAP  = 3'd2,   // ADDREN held, time stamp captured at end of cycle
      ST_CLR  = 3'd3,   // SYNC pulse, word pushed into the FIFO
      ST_GAP  = 3'd4    // guard cycle so the cleared STATE is visible
   } seg_state_t;

   // Widest readout word the packing helper can build.
   localparam int MAX_WORD_W = 64;

   // ceil(log2(value)), with clog2(1) = 0. Usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   // Build a readout word {idx, stamp}. The stamp occupies the low time_w
   // bits; callers pass zero-extended fields and cast the result down to
   // their own word width.
   function automatic logic [MAX_WORD_W-1:0] pack_word(
      input int          time_w,
      input logic [31:0] idx,
      input logic [31:0] stamp
   );
      return ({32'd0, idx} << time_w) | {32'd0, stamp};
   endfunction

endpackage : pixel_readout_pkg
`default_nettype wire

// File: rtl/pixel_seg_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_seg_readout
// Purpose  : Readout engine for one column segment. Picks a hit pixel
//            (fixed or round-robin priority), strobes its ADDREN for two
//            cycles, captures its time stamp, pulses SYNC to clear it and
//            pushes {local_idx, time} into a small output FIFO.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable          - allow new readouts to start
//            pix_state       - per-pixel hit flags of this segment
//            pix_time        - per-pixel time stamps, pixel i at [i*TIME_W +: TIME_W]
//            pix_addren      - one-hot address enable (SEL and CAP states)
//            pix_sync        - one-hot clear pulse (CLR state)
//            rd_valid/ready  - FIFO output handshake
//            rd_data         - FIFO head word {local_idx, time}, 0 when empty
//            busy            - FSM active or FIFO holding data
// Revision : 1.0  initial release
// ============================================================================
module pixel_seg_readout
   import pixel_readout_pkg::*;
#(
   parameter  int PPS        = 90,
   parameter  int TIME_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   parameter  int RR_EN      = 0,
   localparam int IDX_W      = clog2(PPS),
   localparam int WORD_W     = IDX_W + TIME_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [PPS-1:0]        pix_state,
   input  logic [PPS*TIME_W-1:0] pix_time,
   output logic [PPS-1:0]        pix_addren,
   output logic [PPS-1:0]        pix_sync,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [WORD_W-1:0]     rd_data,
   output logic                  busy
);

   localparam int PTR_W = clog2(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   seg_state_t          state;
   logic [IDX_W-1:0]    sel_idx;      // winner latched in IDLE
   logic [IDX_W-1:0]    rr_ptr;       // round-robin search start
   logic [TIME_W-1:0]   cap_time;     // time stamp captured in CAP

   logic [WORD_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W:0]      count;

   // ------------------------------------------------------------------
   // Arbiter
   // Scanning from the top index down leaves the lowest matching index in
   // each result: lo_idx is the lowest hit overall, hi_idx the lowest hit
   // at or above the round-robin pointer. When nothing sits at or above
   // the pointer the search wraps, which is exactly lo_idx.
   // ------------------------------------------------------------------
   logic                any_hit;
   logic                hi_found;
   logic [IDX_W-1:0]    hi_idx;
   logic [IDX_W-1:0]    lo_idx;
   logic [IDX_W-1:0]    win_idx;

   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = PPS - 1; i >= 0; i--) begin
         if (pix_state[i]) begin
            lo_idx = IDX_W'(i);
            if (IDX_W'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
   end

   assign any_hit = |pix_state;
   assign win_idx = ((RR_EN != 0) && hi_found) ? hi_idx : lo_idx;

   // Time stamp of the latched winner; only meaningful during CAP.
   logic [TIME_W-1:0] sel_time;
   assign sel_time = pix_time[int'(sel_idx) * TIME_W +: TIME_W];

   // ------------------------------------------------------------------
   // FIFO status and handshake
   // ------------------------------------------------------------------
   logic                full;
   logic                push;
   logic                pop;
   logic [WORD_W-1:0]   push_word;

   assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
   assign push      = (state == ST_CLR);
   assign pop       = rd_valid && rd_ready;
   assign push_word = WORD_W'(pack_word(TIME_W, 32'(sel_idx), 32'(cap_time)));

   // ------------------------------------------------------------------
   // Readout FSM
   // The FIFO-full test happens only in IDLE. A readout pushes three
   // cycles later and nothing else pushes in between, so the slot seen
   // free in IDLE is still free at CLR even if no pop occurs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         sel_idx  <= '0;
         cap_time <= '0;
         rr_ptr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && any_hit && !full) begin
                  sel_idx <= win_idx;
                  state   <= ST_SEL;
               end
            end
            ST_SEL: begin
               state <= ST_CAP;
            end
            ST_CAP: begin
               cap_time <= sel_time;
               state    <= ST_CLR;
            end
            ST_CLR: begin
               if (RR_EN != 0) begin
                  rr_ptr <= (sel_idx == IDX_W'(PPS - 1)) ? '0 : sel_idx + IDX_W'(1);
               end
               state <= ST_GAP;
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from the state register so reset clears
   // them from the first cycle after the reset edge.
   always_comb begin
      pix_addren = '0;
      pix_sync   = '0;
      if (state == ST_SEL || state == ST_CAP) begin
         pix_addren[sel_idx] = 1'b1;
      end
      if (state == ST_CLR) begin
         pix_sync[sel_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible because
   // the output is gated by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign busy     = (state != ST_IDLE) || rd_valid;

endmodule : pixel_seg_readout
`default_nettype wire

// File: rtl/pixel_column_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_column_readout
// Purpose  : Readout engine for a column of hit-latching pixels. The column
//            is split into NUM_SEG independent segments, each served by its
//            own pixel_seg_readout; this level only slices the buses and
//            combines the busy flags.
// Ports    : sys_clock, sys_reset - clock, synchronous active-high reset
//            enable_i             - allow segments to start new readouts
//            pix_state_i          - per-pixel hit flags
//            pix_time_i           - per-pixel time stamps, pixel p at [p*TIME_W +: TIME_W]
//            pix_addren_o         - per-pixel address enable
//            pix_sync_o           - per-pixel clear pulse
//            rd_valid_o/rd_ready_i- per-segment FIFO handshake
//            rd_data_o            - segment s word at [s*WORD_W +: WORD_W], {local_idx, time}
//            busy_o               - any segment active or holding data
// Revision : 1.0  initial release
// ============================================================================
module pixel_column_readout
   import pixel_readout_pkg::*;
#(
   parameter  int NUM_PIX    = 180,
   parameter  int NUM_SEG    = 2,
   parameter  int TIME_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   parameter  int RR_EN      = 0,
   localparam int PPS        = NUM_PIX / NUM_SEG,
   localparam int IDX_W      = clog2(PPS),
   localparam int WORD_W     = IDX_W + TIME_W
) (
   input  logic                       sys_clock,
   input  logic                       sys_reset,
   input  logic                       enable_i,
   input  logic [NUM_PIX-1:0]         pix_state_i,
   input  logic [NUM_PIX*TIME_W-1:0]  pix_time_i,
   output logic [NUM_PIX-1:0]         pix_addren_o,
   output logic [NUM_PIX-1:0]         pix_sync_o,
   output logic [NUM_SEG-1:0]         rd_valid_o,
   input  logic [NUM_SEG-1:0]         rd_ready_i,
   output logic [NUM_SEG*WORD_W-1:0]  rd_data_o,
   output logic                       busy_o
);

   logic [NUM_SEG-1:0] seg_busy;

   // Segment s owns pixels s*PPS .. s*PPS+PPS-1 and reports local indices.
   for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
      pixel_seg_readout #(
         .PPS        (PPS),
         .TIME_W     (TIME_W),
         .FIFO_DEPTH (FIFO_DEPTH),
         .RR_EN      (RR_EN)
      ) u_seg (
         .clk        (sys_clock),
         .rst        (sys_reset),
         .enable     (enable_i),
         .pix_state  (pix_state_i[s*PPS +: PPS]),
         .pix_time   (pix_time_i[s*PPS*TIME_W +: PPS*TIME_W]),
         .pix_addren (pix_addren_o[s*PPS +: PPS]),
         .pix_sync   (pix_sync_o[s*PPS +: PPS]),
         .rd_valid   (rd_valid_o[s]),
         .rd_ready   (rd_ready_i[s]),
         .rd_data    (rd_data_o[s*WORD_W +: WORD_W]),
         .busy       (seg_busy[s])
      );
   end : g_seg

   assign busy_o = |seg_busy;

endmodule : pixel_column_readout
`default_nettype wire

// File: tb/tb_pixel_column_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_column_readout
// Purpose  : Self-checking bench for pixel_column_readout. Two instances run
//            side by side: one in fixed-priority mode, one in round-robin
//            mode. Expected words are queued when stimulus is issued and a
//            separate monitor pops and compares them on every accepted word.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_column_readout;

   localparam int NUM_PIX    = 180;
   localparam int NUM_SEG    = 2;
   localparam int TIME_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int IDX_W      = 7;
   localparam int WORD_W     = IDX_W + TIME_W;

   logic                      sys_clock;
   logic                      sys_reset;
   logic                      enable_i;
   logic [NUM_PIX-1:0]        state_f, state_r;
   logic [NUM_PIX*TIME_W-1:0] time_f, time_r;
   logic [NUM_PIX-1:0]        addren_f, sync_f, addren_r, sync_r;
   logic [NUM_SEG-1:0]        valid_f, ready_f, valid_r, ready_r;
   logic [NUM_SEG*WORD_W-1:0] data_f, data_r;
   logic                      busy_f, busy_r;

   pixel_column_readout #(
      .NUM_PIX(NUM_PIX), .NUM_SEG(NUM_SEG), .TIME_W(TIME_W),
      .FIFO_DEPTH(FIFO_DEPTH), .RR_EN(0)
   ) dut_fixed (
      .sys_clock(sys_clock), .sys_reset(sys_reset), .enable_i(enable_i),
      .pix_state_i(state_f), .pix_time_i(time_f),
      .pix_addren_o(addren_f), .pix_sync_o(sync_f),
      .rd_valid_o(valid_f), .rd_ready_i(ready_f), .rd_data_o(data_f),
      .busy_o(busy_f)
   );

   pixel_column_readout #(
      .NUM_PIX(NUM_PIX), .NUM_SEG(NUM_SEG), .TIME_W(TIME_W),
      .FIFO_DEPTH(FIFO_DEPTH), .RR_EN(1)
   ) dut_rr (
      .sys_clock(sys_clock), .sys_reset(sys_reset), .enable_i(enable_i),
      .pix_state_i(state_r), .pix_time_i(time_r),
      .pix_addren_o(addren_r), .pix_sync_o(sync_r),
      .rd_valid_o(valid_r), .rd_ready_i(ready_r), .rd_data_o(data_r),
      .busy_o(busy_r)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   // ------------------------------------------------------------------
   // Scoreboard: streams 0,1 = fixed seg0/seg1, 2,3 = round-robin seg0/seg1
   // ------------------------------------------------------------------
   logic [WORD_W-1:0] exp_q [4][$];

   typedef struct packed {
      logic [127:0] name;
      logic [31:0]  act;
      logic [31:0]  exp;
   } dchk_t;
   dchk_t dir_q[$];

   int n_pass;
   int n_total;
   bit [3:0]          prev_stall;
   logic [WORD_W-1:0] prev_data [4];

   always @(negedge sys_clock) begin
      logic [3:0]        mv;
      logic [3:0]        mr;
      logic [WORD_W-1:0] md [4];
      logic [WORD_W-1:0] e;
      dchk_t             d;
      mv = {valid_r, valid_f};
      mr = {ready_r, ready_f};
      md[0] = data_f[0 +: WORD_W];
      md[1] = data_f[WORD_W +: WORD_W];
      md[2] = data_r[0 +: WORD_W];
      md[3] = data_r[WORD_W +: WORD_W];
      while (dir_q.size() > 0) begin
         d = dir_q.pop_front();
         n_total++;
         if (d.act == d.exp) n_pass++;
         else $display("FAIL %0s: got %0d, want %0d", d.name, d.act, d.exp);
      end
      for (int s = 0; s < 4; s++) begin
         if (prev_stall[s] && !sys_reset) begin
            n_total++;
            if (mv[s] && md[s] == prev_data[s]) n_pass++;
            else $display("FAIL hold_s%0d: valid=%0b data=%h, want valid=1 data=%h",
                          s, mv[s], md[s], prev_data[s]);
         end
         if (mv[s] && mr[s]) begin
            n_total++;
            if (exp_q[s].size() == 0) begin
               $display("FAIL word_s%0d: got %h, want no word", s, md[s]);
            end else begin
               e = exp_q[s].pop_front();
               if (md[s] == e) n_pass++;
               else $display("FAIL word_s%0d: got %h, want %h", s, md[s], e);
            end
         end
         prev_stall[s] = mv[s] && !mr[s];
         prev_data[s]  = md[s];
      end
   end

   // ------------------------------------------------------------------
   // Pixel model and stimulus helpers
   // ------------------------------------------------------------------
   int                addren_cnt_f [NUM_PIX];
   int                sync_cnt_f   [NUM_PIX];
   int                sync_cnt_r   [NUM_PIX];
   logic [NUM_PIX-1:0] rehit_f, rehit_r;
   int                rehit_left_f, rehit_left_r;

   task automatic post(input logic [127:0] name, input int act, input int exp);
      dchk_t d;
      d.name = name;
      d.act  = 32'(act);
      d.exp  = 32'(exp);
      dir_q.push_back(d);
   endtask

   function automatic logic [WORD_W-1:0] word(input int idx, input int t);
      return {IDX_W'(idx), TIME_W'(t)};
   endfunction

   function automatic int sum_cnt(input int a [NUM_PIX]);
      int s;
      s = 0;
      for (int p = 0; p < NUM_PIX; p++) s += a[p];
      return s;
   endfunction

   task automatic set_f(input int p, input int t);
      state_f[p] = 1'b1;
      time_f[p*TIME_W +: TIME_W] = TIME_W'(t);
   endtask

   task automatic set_r(input int p, input int t);
      state_r[p] = 1'b1;
      time_r[p*TIME_W +: TIME_W] = TIME_W'(t);
   endtask

   task automatic clear_counts();
      for (int p = 0; p < NUM_PIX; p++) begin
         addren_cnt_f[p] = 0;
         sync_cnt_f[p]   = 0;
         sync_cnt_r[p]   = 0;
      end
   endtask

   // One clock; inputs change and strobes are observed 1 unit after the
   // rising edge. A SYNC clears the pixel unless it is marked to re-hit.
   task automatic tick();
      @(posedge sys_clock);
      #1;
      for (int p = 0; p < NUM_PIX; p++) begin
         if (addren_f[p]) addren_cnt_f[p]++;
         if (sync_f[p]) begin
            sync_cnt_f[p]++;
            if (rehit_f[p] && rehit_left_f > 0) rehit_left_f--;
            else state_f[p] = 1'b0;
         end
         if (sync_r[p]) begin
            sync_cnt_r[p]++;
            if (rehit_r[p] && rehit_left_r > 0) rehit_left_r--;
            else state_r[p] = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input int budget, input logic [127:0] name, output int n);
      n = 0;
      while ((busy_f || busy_r || (enable_i && ((|state_f) || (|state_r)))) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) post(name, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int n;
      int bad;
      sys_reset    = 1'b1;
      enable_i     = 1'b0;
      state_f      = '0;
      state_r      = '0;
      time_f       = '0;
      time_r       = '0;
      ready_f      = '1;
      ready_r      = '1;
      rehit_f      = '0;
      rehit_r      = '0;
      rehit_left_f = 0;
      rehit_left_r = 0;
      clear_counts();
      repeat (3) tick();

      // Reset state
      post("rst_addren", $countones(addren_f), 0);
      post("rst_sync",   $countones(sync_f), 0);
      post("rst_valid",  int'(valid_f), 0);
      post("rst_data",   int'(data_f != '0), 0);
      post("rst_busy",   int'(busy_f), 0);
      post("rst_busy_rr", int'(busy_r), 0);
      sys_reset = 1'b0;
      enable_i  = 1'b1;
      tick();

      // Single hit: pixel 5, time 0x2A
      clear_counts();
      exp_q[0].push_back(word(5, 8'h2A));
      set_f(5, 8'h2A);
      n = 0;
      while (!valid_f[0] && n < 20) begin
         tick();
         n++;
      end
      post("t1_latency", n, 4);
      wait_done(50, "t1_timeout", n);
      post("t1_addren5", addren_cnt_f[5], 2);
      post("t1_sync5", sync_cnt_f[5], 1);
      post("t1_syncs", sum_cnt(sync_cnt_f), 1);

      // Every pixel hit, time = p + 4
      clear_counts();
      for (int p = 0; p < NUM_PIX; p++) set_f(p, p + 4);
      for (int k = 0; k < 90; k++) begin
         exp_q[0].push_back(word(k, k + 4));
         exp_q[1].push_back(word(k, 90 + k + 4));
      end
      wait_done(700, "t2_timeout", n);
      post("t2_cycles", n, 450);
      bad = 0;
      for (int p = 0; p < NUM_PIX; p++) if (sync_cnt_f[p] != 1) bad++;
      post("t2_sync_once", bad, 0);
      post("t2_q0_empty", exp_q[0].size(), 0);
      post("t2_q1_empty", exp_q[1].size(), 0);

      // Backpressure: 10 hits in seg0 with its consumer stalled
      clear_counts();
      ready_f = 2'b10;
      for (int i = 0; i < 10; i++) begin
         set_f(10 + i, 8'h50 + i);
         exp_q[0].push_back(word(10 + i, 8'h50 + i));
      end
      repeat (60) tick();
      post("t3_sync_stall", sum_cnt(sync_cnt_f), 4);
      post("t3_addren_stall", sum_cnt(addren_cnt_f), 8);
      post("t3_valid_stall", int'(valid_f[0]), 1);
      ready_f = 2'b11;
      wait_done(200, "t3_timeout", n);
      bad = 0;
      for (int p = 10; p < 20; p++) if (sync_cnt_f[p] != 1) bad++;
      post("t3_sync_once", bad, 0);
      post("t3_sync_total", sum_cnt(sync_cnt_f), 10);
      post("t3_q0_empty", exp_q[0].size(), 0);

      // Pixels 2 and 7 re-hit after their first SYNCs (two re-hits each DUT)
      clear_counts();
      rehit_f[2] = 1'b1; rehit_f[7] = 1'b1;
      rehit_r[2] = 1'b1; rehit_r[7] = 1'b1;
      rehit_left_f = 2;
      rehit_left_r = 2;
      set_f(2, 8'h32); set_f(7, 8'h37);
      set_r(2, 8'h32); set_r(7, 8'h37);
      exp_q[0].push_back(word(2, 8'h32));
      exp_q[0].push_back(word(2, 8'h32));
      exp_q[0].push_back(word(2, 8'h32));
      exp_q[0].push_back(word(7, 8'h37));
      exp_q[2].push_back(word(2, 8'h32));
      exp_q[2].push_back(word(7, 8'h37));
      exp_q[2].push_back(word(2, 8'h32));
      exp_q[2].push_back(word(7, 8'h37));
      wait_done(100, "t4_timeout", n);
      post("t4_fix_q_empty", exp_q[0].size(), 0);
      post("t4_rr_q_empty", exp_q[2].size(), 0);
      post("t4_fix_sync2", sync_cnt_f[2], 3);
      post("t4_rr_sync7", sync_cnt_r[7], 2);
      rehit_f = '0;
      rehit_r = '0;

      // Reset pulsed while pixel 40 is in CAP
      clear_counts();
      set_f(40, 8'h77);
      tick();
      tick();
      post("t5_addren_cap", int'(addren_f[40]), 1);
      sys_reset = 1'b1;
      tick();
      post("t5_addren", $countones(addren_f), 0);
      post("t5_sync", $countones(sync_f), 0);
      post("t5_valid", int'(valid_f), 0);
      post("t5_busy", int'(busy_f), 0);
      post("t5_sync40", sync_cnt_f[40], 0);
      sys_reset = 1'b0;
      exp_q[0].push_back(word(40, 8'h77));
      wait_done(50, "t5_timeout", n);
      post("t5_reread", sync_cnt_f[40], 1);
      post("t5_q0_empty", exp_q[0].size(), 0);

      // Enable dropped in SEL with three hits pending
      clear_counts();
      set_f(60, 8'h60); set_f(61, 8'h61); set_f(62, 8'h62);
      exp_q[0].push_back(word(60, 8'h60));
      tick();
      post("t6_sel60", int'(addren_f[60]), 1);
      enable_i = 1'b0;
      repeat (20) tick();
      post("t6_sync60", sync_cnt_f[60], 1);
      post("t6_others", sync_cnt_f[61] + sync_cnt_f[62], 0);
      post("t6_busy_off", int'(busy_f), 0);
      enable_i = 1'b1;
      exp_q[0].push_back(word(61, 8'h61));
      exp_q[0].push_back(word(62, 8'h62));
      wait_done(50, "t6_timeout", n);
      post("t6_sync61", sync_cnt_f[61], 1);
      post("t6_sync62", sync_cnt_f[62], 1);
      post("t6_q0_empty", exp_q[0].size(), 0);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_pixel_column_readout
`default_nettype wire

// File: doc/pixel_column_readout.md
Name: pixel_column_readout

Overview:
Synthesizable readout engine for a column of hit-latching pixels. The column is split into NUM_SEG independent segments. Each segment priority-selects a hit pixel, drives its ADDREN to capture its time stamp, then pulses its SYNC to clear it. Each readout word is pushed into a per-segment output FIFO with a valid/ready handshake. It generalises the fixed 180-pixel, two-half (up/down) priority readout: pixel count, segment count, time width, FIFO depth and arbitration mode are all parameters.

Parameters:
NUM_PIX, 180, total pixels in the column; must be divisible by NUM_SEG
NUM_SEG, 2, independent readout segments; segment s owns pixels s*PPS .. s*PPS+PPS-1
TIME_W, 8, pixel time-stamp width
FIFO_DEPTH, 4, output FIFO words per segment; must be a power of 2 and at least 2
RR_EN, 0, 0 = fixed priority (lowest local index wins); 1 = round-robin starting at last served index + 1
Derived (localparam): PPS = NUM_PIX/NUM_SEG; IDX_W = clog2(PPS); WORD_W = IDX_W + TIME_W

Ports:
sys_clock  in  1  single clock, all logic on rising edge
sys_reset  in  1  synchronous, active-high reset
enable_i  in  1  1 = segments may start new readouts
pix_state_i  in  NUM_PIX  per-pixel hit flag (STATE)
pix_time_i  in  NUM_PIX*TIME_W  per-pixel time stamp; pixel p occupies [p*TIME_W +: TIME_W]
pix_addren_o  out  NUM_PIX  per-pixel address enable, one-hot within a segment
pix_sync_o  out  NUM_PIX  per-pixel clear pulse, one-hot within a segment
rd_valid_o  out  NUM_SEG  segment FIFO not empty
rd_ready_i  in  NUM_SEG  consumer accept
rd_data_o  out  NUM_SEG*WORD_W  segment s word at [s*WORD_W +: WORD_W], format {local_idx, time}
busy_o  out  1  OR over segments of (FSM not IDLE or FIFO not empty)

Behaviour:
- Reset: all outputs 0, FSMs in IDLE, FIFOs empty, rr pointers 0. Reset asserted mid-readout aborts the readout; no SYNC is issued, and ADDREN/SYNC are low from the first cycle after the reset edge.
- Per-segment FSM (all segments identical and fully independent):
  - IDLE: if enable_i, segment has any hit, and FIFO not full: latch winner index -> SEL. Otherwise stay.
  - SEL: pix_addren_o[winner] = 1 -> CAP.
  - CAP: pix_addren_o[winner] = 1; latch pix_time_i[winner] -> CLR.
  - CLR: pix_sync_o[winner] = 1 for exactly this cycle; push {idx, time} into FIFO; if RR_EN, rr pointer = idx+1, wrapping PPS-1 -> 0 -> GAP.
  - GAP: all strobes low; one-cycle guard so the pixel's cleared STATE is seen before re-arbitration -> IDLE.
- Throughput: 1 hit per 5 cycles per segment. Latency from hit sampled in IDLE (cycle 0) to rd_valid_o high: cycle 4 (push in cycle 3, FIFO registered).
- Arbitration: fixed mode picks the lowest local index. RR mode picks the first hit at or above the pointer, wrapping; if only the pointer's pixel is hit, it is picked.
- Pixels whose state falls before selection are simply not chosen. The winner is latched at IDLE; later state changes do not affect the readout in progress.
- FIFO: push on CLR, pop on rd_valid_o & rd_ready_i. Simultaneous push and pop when full is legal because the full check happened at IDLE. Data is held stable while valid and not ready. No drop and no overflow: a full FIFO stalls the FSM in IDLE.
- enable_i deasserted mid-readout: the current readout completes through GAP; no new selection starts.
- No hits anywhere: all strobes stay 0.

Decomposition:
- pixel_readout_pkg: FSM state enum (IDLE, SEL, CAP, CLR, GAP), clog2 function, and a word-packing function {idx, time}.
- Sub-module pixel_seg_readout (FSM, arbiter, rr pointer, FIFO), instantiated NUM_SEG times by a generate loop in the top. The top only slices the buses and ORs busy.

Test Plan:
- Defaults, only pixel 5 hit with time 0x2A, ready=1 -> seg0 ADDREN[5] high for 2 cycles, SYNC[5] pulses once, rd_data_o seg0 = {7'd5, 8'h2A} with valid 4 cycles after the hit.
- All 180 pixels hit, time = p+4, ready=1 -> each segment emits 90 words in ascending local index. Seg1 word k = {k, 8'(90+k+4)}, each pixel cleared exactly once, busy_o falls after the last pop.
- Backpressure: ready=0 with 10 hits in seg0 -> exactly FIFO_DEPTH=4 words are read, and no ADDREN/SYNC occurs until ready=1. Then the remaining 6 are read with no loss or duplication.
- RR_EN=1, pixels 2 and 7 held re-hit after every SYNC -> service order 2, 7, 2, 7. Fixed mode under the same stimulus -> 2, 2, 2.
- sys_reset pulsed during CAP -> no SYNC for that pixel, outputs 0 next cycle, FIFO empty. The pixel's hit is re-read after reset release.
- enable_i dropped in SEL with 3 hits pending -> that readout completes; the other two are not read until enable_i returns.
